// File: rtl/shuf_arb.sv
// Two-requester burst arbiter feeding a one-word output register; each granted
// word is passed through or bit-reversed according to its requester's mode bit.
module shuf_arb #(
  parameter int WIDTH = 64,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_rev,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_rev,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_rev
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_own_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             w_accept;
  logic             w_has_owner;
  logic             w_owner;
  logic             w_burst_done;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_rev;
  logic [WIDTH-1:0] w_shuf;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             r_out_rev;

  // Owner selection; w_owner is 0 for A and 1 for B, and only meaningful with w_has_owner.
  always_comb begin
    w_has_owner  = 1'b0;
    w_owner      = 1'b0;
    w_burst_done = (r_cnt == BURST_C);
    case (r_state)
      OWN_A: begin
        if (a_valid && !(w_burst_done && b_valid)) begin
          w_has_owner = 1'b1;
          w_owner     = 1'b0;
        end else if (b_valid) begin
          w_has_owner = 1'b1;
          w_owner     = 1'b1;
        end
      end
      OWN_B: begin
        if (b_valid && !(w_burst_done && a_valid)) begin
          w_has_owner = 1'b1;
          w_owner     = 1'b1;
        end else if (a_valid) begin
          w_has_owner = 1'b1;
          w_owner     = 1'b0;
        end
      end
      default: begin
        if (a_valid && b_valid) begin
          w_has_owner = 1'b1;
          w_owner     = ~r_last;
        end else if (a_valid || b_valid) begin
          w_has_owner = 1'b1;
          w_owner     = b_valid;
        end
      end
    endcase
  end

  assign w_accept = !r_out_valid || out_ready;
  assign a_ready  = !rst && w_accept && w_has_owner && !w_owner && a_valid;
  assign b_ready  = !rst && w_accept && w_has_owner && w_owner && b_valid;
  assign w_xfer   = a_ready || b_ready;
  assign w_own_state = w_owner ? OWN_B : OWN_A;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    if (w_xfer) begin
      w_state_nxt = w_own_state;
      w_last_nxt  = w_owner;
      if (r_state == w_own_state && !w_burst_done) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        w_cnt_nxt = CW'(1);
      end
    end else if (!a_valid && !b_valid) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // last_owner resets to B so that A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_sel_data = w_owner ? b_data : a_data;
    w_sel_rev  = w_owner ? b_rev : a_rev;
    w_shuf     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_shuf[i] = w_sel_rev ? w_sel_data[WIDTH-1-i] : w_sel_data[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
      r_out_rev   <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_shuf;
      r_out_src   <= w_owner;
      r_out_rev   <= w_sel_rev;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_rev   = r_out_rev;

endmodule
